// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_t   : FSM state encoding (IDLE/LOAD/FILL/RUN)
//   PAT_W_DEF : default pattern length
//   CNT_W_DEF : default match counter width
//   load_len  : number of load bits that make a complete load burst
// Config macro: SEQ_DET_MASK_EN (a burst carries a pattern followed by a mask)
package seq_det_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FILL = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam int unsigned PAT_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  function automatic int unsigned load_len(input int unsigned pat_w);
`ifdef SEQ_DET_MASK_EN
    return 2 * pat_w;
`else
    return pat_w;
`endif
  endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// Serial-in / parallel-out shift register, LSB is the newest bit.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear contents; combined with en the register restarts
//                holding only the incoming bit
//   en         : shift sin in at the LSB
//   sin        : serial input
//   q          : parallel contents
module seq_det_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] base;

  always_comb begin
    base = clr ? '0 : q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= W'({base, sin});
    end else if (clr) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable serial pattern detector.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   bit_en    : sample strobe; load/din only acted on when high
//   load      : 1 = din is a pattern bit (MSB first), 0 = din is data
//   din       : serial bit
//   overlap   : 1 = overlapping detection, 0 = restart after each match
//   dout      : registered 1-cycle match pulse
//   armed     : high while the detector is in RUN
//   match_cnt : saturating match count since the last load
// Config macro: SEQ_DET_MASK_EN adds a serially loaded compare mask
// (1 = compare, 0 = don't care) following the pattern bits.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = PAT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             load,
  input  logic             din,
  input  logic             overlap,
  output logic             dout,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned LOAD_MAX = load_len(PAT_W);
  localparam int unsigned LC_W     = $clog2(LOAD_MAX + 1);
  localparam int unsigned FC_W     = $clog2(PAT_W);

  state_t             state_q, state_d;
  logic [LC_W-1:0]    load_cnt_q, load_cnt_d;
  logic [FC_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]   match_cnt_d;
  logic               dout_d;
  logic               pat_en, sr_en, sr_clr, hit;
  logic [PAT_W-1:0]   pat_q, window;
  // Only the PAT_W-1 most recent data bits are stored; din completes the window.
  logic [PAT_W-2:0]   data_q;

  seq_det_shreg #(.W(PAT_W)) u_pat (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(pat_en), .sin(din), .q(pat_q)
  );

  seq_det_shreg #(.W(PAT_W - 1)) u_data (
    .clk(clk), .rst_n(rst_n), .clr(sr_clr), .en(sr_en), .sin(din), .q(data_q)
  );

  assign window = {data_q, din};

`ifdef SEQ_DET_MASK_EN
  logic             mask_en;
  logic [PAT_W-1:0] mask_q;

  seq_det_shreg #(.W(PAT_W)) u_mask (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(mask_en), .sin(din), .q(mask_q)
  );

  assign hit = ((window ^ pat_q) & mask_q) == '0;
`else
  assign hit = (window == pat_q);
`endif

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt;
    dout_d      = 1'b0;
    pat_en      = 1'b0;
    sr_en       = 1'b0;
    sr_clr      = 1'b0;
`ifdef SEQ_DET_MASK_EN
    mask_en     = 1'b0;
`endif
    if (bit_en) begin
      if (load) begin
        state_d = S_LOAD;
        if (state_q != S_LOAD) begin
          load_cnt_d  = LC_W'(1);
          match_cnt_d = '0;
          pat_en      = 1'b1;
        end else begin
`ifdef SEQ_DET_MASK_EN
          // First PAT_W bits of the burst fill the pattern, the rest the mask.
          if (load_cnt_q < LC_W'(PAT_W)) pat_en = 1'b1;
          else                           mask_en = 1'b1;
`else
          pat_en = 1'b1;
`endif
          if (load_cnt_q != LC_W'(LOAD_MAX)) load_cnt_d = load_cnt_q + 1'b1;
        end
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_cnt_q == LC_W'(LOAD_MAX)) begin
              // This din is already the first fill bit.
              state_d    = S_FILL;
              sr_clr     = 1'b1;
              sr_en      = 1'b1;
              fill_cnt_d = FC_W'(1);
            end else begin
              state_d = S_IDLE;
            end
          end
          S_FILL, S_RUN: begin
            sr_en = 1'b1;
            if (state_q == S_FILL && fill_cnt_q != FC_W'(PAT_W - 1)) begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end else begin
              state_d = S_RUN;
              if (hit) begin
                dout_d = 1'b1;
                if (match_cnt != '1) match_cnt_d = match_cnt + 1'b1;
                if (!overlap) begin
                  state_d    = S_FILL;
                  fill_cnt_d = '0;
                  sr_en      = 1'b0;
                  sr_clr     = 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      fill_cnt_q <= '0;
      match_cnt  <= '0;
      dout       <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      match_cnt  <= match_cnt_d;
      dout       <= dout_d;
    end
  end

  assign armed = (state_q == S_RUN);

endmodule

// File: tb/tb_seq_det_prog.sv
// Self-checking bench for seq_det_prog (PAT_W=8, CNT_W=2 to reach saturation).
// Reference model works on bit queues: the load burst and the data bits
// seen since the last (re)start of matching.
module tb_seq_det_prog;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
`ifdef SEQ_DET_MASK_EN
  localparam int unsigned LOAD_MAX = 2 * PAT_W;
`else
  localparam int unsigned LOAD_MAX = PAT_W;
`endif
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, bit_en = 1'b0, load = 1'b0, din = 1'b0, overlap = 1'b0;
  logic dout, armed;
  logic [CNT_W-1:0] match_cnt;

  int unsigned n_chk = 0, n_pass = 0, pulses = 0;

  seq_det_prog #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .load(load), .din(din),
    .overlap(overlap), .dout(dout), .armed(armed), .match_cnt(match_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  bit          ld_q[$];
  bit          dq[$];
  bit          m_loading = 1'b0, m_watch = 1'b0;
  int unsigned m_pat = 0, m_mask = 0, m_cnt = 0;

  function automatic bit m_armed();
    return m_watch && (dq.size() == PAT_W);
  endfunction

  task automatic model_reset();
    ld_q.delete(); dq.delete();
    m_loading = 1'b0; m_watch = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input bit ld, input bit d, input bit ov, output bit e_dout);
    int unsigned w, n;
    e_dout = 1'b0;
    if (ld) begin
      if (!m_loading) begin
        ld_q.delete();
        m_cnt = 0;
      end
      m_loading = 1'b1;
      m_watch   = 1'b0;
      ld_q.push_back(d);
      return;
    end
    if (m_loading) begin
      m_loading = 1'b0;
      n = ld_q.size();
      if (n >= LOAD_MAX) begin
        m_pat = 0; m_mask = 0;
`ifdef SEQ_DET_MASK_EN
        for (int i = 0; i < PAT_W; i++) m_pat = (m_pat << 1) | ld_q[i];
        for (int i = n - PAT_W; i < n; i++) m_mask = (m_mask << 1) | ld_q[i];
`else
        for (int i = n - PAT_W; i < n; i++) m_pat = (m_pat << 1) | ld_q[i];
        m_mask = (1 << PAT_W) - 1;
`endif
        m_watch = 1'b1;
        dq.delete();
      end else begin
        m_watch = 1'b0;
      end
    end
    if (m_watch) begin
      dq.push_back(d);
      if (dq.size() > PAT_W) void'(dq.pop_front());
      if (dq.size() == PAT_W) begin
        w = 0;
        foreach (dq[i]) w = (w << 1) | dq[i];
        if (((w ^ m_pat) & m_mask) == 0) begin
          e_dout = 1'b1;
          if (m_cnt < CMAX) m_cnt++;
          if (!ov) dq.delete();
        end
      end
    end
  endtask

  // ---------------- checking / stimulus helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input bit ld, input bit d, input bit ov, input string tag);
    bit e;
    @(negedge clk);
    load = ld; din = d; overlap = ov; bit_en = 1'b1;
    model_step(ld, d, ov, e);
    @(posedge clk); #1;
    chk({tag, "_dout"}, 32'(dout), 32'(e));
    chk({tag, "_armed"}, 32'(armed), 32'(m_armed()));
    chk({tag, "_cnt"}, 32'(match_cnt), m_cnt);
    if (dout === 1'b1) pulses++;
    @(negedge clk);
    bit_en = 1'b0; load = 1'($urandom); din = 1'($urandom); overlap = 1'($urandom);
    @(posedge clk); #1;
    chk({tag, "_gap_dout"}, 32'(dout), 32'd0);
    chk({tag, "_gap_cnt"}, 32'(match_cnt), m_cnt);
    repeat (2) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] v, input int n, input bit ld, input bit ov,
                           input string tag);
    for (int i = n - 1; i >= 0; i--) send_bit(ld, v[i], ov, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; bit_en = 1'b1; load = 1'($urandom); din = 1'($urandom);
    @(posedge clk); #1;
    model_reset();
    chk({tag, "_rst_dout"}, 32'(dout), 32'd0);
    chk({tag, "_rst_armed"}, 32'(armed), 32'd0);
    chk({tag, "_rst_cnt"}, 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bit_en = 1'b0;
  endtask

  task automatic load_pat(input logic [31:0] p, input logic [31:0] m, input string tag);
    send_word(p, PAT_W, 1'b1, 1'b0, tag);
`ifdef SEQ_DET_MASK_EN
    send_word(m, PAT_W, 1'b1, 1'b0, tag);
`else
    if (m != m) send_word(m, PAT_W, 1'b1, 1'b0, tag);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] lv;
  int unsigned len, p0, top;

  initial begin
    repeat (3) @(posedge clk);
    do_reset("init");

    // 1: A5 non-overlapping, single pulse
    load_pat(32'hA5, 32'hFF, "t1_load");
    p0 = pulses;
    send_word(32'hA5, 8, 1'b0, 1'b0, "t1");
    chk("t1_pulses", pulses - p0, 1);
    chk("t1_final_cnt", 32'(match_cnt), 1);

    // 2: AA overlapping over 12 bits -> pulses at 8,10,12 (counter saturates at 3)
    load_pat(32'hAA, 32'hFF, "t2_load");
    p0 = pulses;
    send_word(32'hAAA, 12, 1'b0, 1'b1, "t2o");
    chk("t2o_pulses", pulses - p0, 3);
    chk("t2o_cnt", 32'(match_cnt), 3);
    load_pat(32'hAA, 32'hFF, "t2n_load");
    p0 = pulses;
    send_word(32'hAAA, 12, 1'b0, 1'b0, "t2n");
    chk("t2n_pulses", pulses - p0, 1);

    // saturation: long overlapping run holds at 2**CNT_W-1
    load_pat(32'hAA, 32'hFF, "sat_load");
    send_word(32'hAAAAAA, 24, 1'b0, 1'b1, "sat");
    chk("sat_cnt", 32'(match_cnt), CMAX);

    // 3: short load -> IDLE, nothing detected
    send_word(32'h15, 5, 1'b1, 1'b0, "t3_load");
    p0 = pulses;
    for (int b = 0; b < 256; b++) send_word(32'(b), 8, 1'b0, 1'b0, "t3");
    chk("t3_pulses", pulses - p0, 0);
    chk("t3_armed", 32'(armed), 0);

    // 4: reset one bit before a match
    load_pat(32'hA5, 32'hFF, "t4_load");
    send_word(32'h00, 8, 1'b0, 1'b1, "t4_fill");
    chk("t4_armed_run", 32'(armed), 1);
    send_word(32'h52, 7, 1'b0, 1'b1, "t4_pre");
    do_reset("t4");
    p0 = pulses;
    send_bit(1'b0, 1'b1, 1'b1, "t4_last");
    chk("t4_pulses", pulses - p0, 0);

    // 5: reload during RUN
    load_pat(32'hA5, 32'hFF, "t5_load");
    send_word(32'hA5, 8, 1'b0, 1'b1, "t5_old");
    send_word(32'h3C, 8, 1'b1, 1'b0, "t5_reload");
`ifdef SEQ_DET_MASK_EN
    send_word(32'hFF, 8, 1'b1, 1'b0, "t5_reload_m");
`endif
    chk("t5_cnt_cleared", 32'(match_cnt), 0);
    chk("t5_armed_cleared", 32'(armed), 0);
    p0 = pulses;
    send_word(32'hA5, 8, 1'b0, 1'b1, "t5_a5");
    chk("t5_a5_pulses", pulses - p0, 0);
    send_word(32'h3C, 8, 1'b0, 1'b1, "t5_3c");
    chk("t5_3c_pulses", pulses - p0, 1);

`ifdef SEQ_DET_MASK_EN
    // 6: masked compare
    load_pat(32'hF0, 32'hF0, "t6_load");
    p0 = pulses;
    send_word(32'hF7, 8, 1'b0, 1'b0, "t6_f7");
    chk("t6_f7_pulses", pulses - p0, 1);
    send_word(32'h70, 8, 1'b0, 1'b0, "t6_70");
    chk("t6_70_pulses", pulses - p0, 1);
`endif

    // randomized bursts: replay loaded pattern mixed with random bits
    for (int k = 0; k < 14; k++) begin
      lv  = $urandom;
      len = LOAD_MAX - 2 + $urandom_range(0, 4);
      for (int i = int'(len) - 1; i >= 0; i--) send_bit(1'b1, lv[i], 1'($urandom), "rnd_load");
      top = (LOAD_MAX == PAT_W) ? PAT_W - 1 : len - 1;
      for (int c = 0; c < 8; c++) begin
        if ($urandom_range(0, 1) == 0) begin
          for (int i = int'(top); i > int'(top) - int'(PAT_W); i--)
            send_bit(1'b0, lv[i], 1'($urandom), "rnd_pat");
        end else begin
          for (int i = 0; i < int'($urandom_range(1, 5)); i++)
            send_bit(1'b0, 1'($urandom), 1'($urandom), "rnd_data");
        end
        if ($urandom_range(0, 19) == 0) do_reset("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
